// File: rtl/mem_bus_pkg.sv
// Shared constants and helpers for the native processor memory bus.
// Master IDs, default bus widths, request decode and a saturating counter step.
package mem_bus_pkg;

  localparam logic MID_CPU = 1'b0;
  localparam logic MID_AUX = 1'b1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  function automatic logic is_req(input logic rstrb, input logic [MASK_W-1:0] wmask);
    return rstrb | (|wmask);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// {valid, id} delay line tagging each slave read with the master that issued it.
// Latency: DEPTH cycles in to out; never stalls, accepts one tag every cycle.
module mem_rd_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_vld_i,
  input  logic in_id_i,
  output logic out_vld_o,
  output logic out_id_o
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] id_q, id_d;

  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    vld_d[0] = in_vld_i;
    id_d[0]  = in_id_i;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  // Clearing the valids on reset is what discards in-flight read responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign out_vld_o = vld_q[DEPTH-1];
  assign out_id_o  = id_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin two-master arbiter for one RAM port; MEM_ARBITER_STATS_EN adds grant/conflict counters.
// Latency: zero-cycle request mux, RD_LATENCY-cycle tagged rvalid; loser sees busy until granted.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = mem_bus_pkg::ADDR_W,
  parameter int DATA_W     = mem_bus_pkg::DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_rstrb_i,
  input  logic [DATA_W/8-1:0] m0_wmask_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_rvalid_o,
  output logic                m0_busy_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic                m1_rstrb_i,
  input  logic [DATA_W/8-1:0] m1_wmask_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_rvalid_o,
  output logic                m1_busy_o,
`ifdef MEM_ARBITER_STATS_EN
  output logic [31:0]         m0_grants_o,
  output logic [31:0]         m1_grants_o,
  output logic [31:0]         conflicts_o,
`endif
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic                s_rstrb_o,
  output logic [DATA_W/8-1:0] s_wmask_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic [DATA_W-1:0]   s_rdata_i
);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                rstrb;
    logic [DATA_W/8-1:0] wmask;
    logic [DATA_W-1:0]   wdata;
  } req_t;

  req_t m0_req, m1_req, s_req;
  logic m0_vld, m1_vld;
  logic gnt_vld, gnt_id;
  logic last_q, last_d;
  logic tag_vld, tag_id;

  always_comb begin
    m0_req.addr  = m0_addr_i;
    m0_req.rstrb = m0_rstrb_i;
    m0_req.wmask = m0_wmask_i;
    m0_req.wdata = m0_wdata_i;
    m1_req.addr  = m1_addr_i;
    m1_req.rstrb = m1_rstrb_i;
    m1_req.wmask = m1_wmask_i;
    m1_req.wdata = m1_wdata_i;

    m0_vld  = is_req(m0_rstrb_i, m0_wmask_i);
    m1_vld  = is_req(m1_rstrb_i, m1_wmask_i);
    gnt_vld = m0_vld | m1_vld;

    // On a tie the master that did not win last time goes first.
    gnt_id = MID_CPU;
    if (m0_vld && m1_vld) gnt_id = ~last_q;
    else if (m1_vld)      gnt_id = MID_AUX;

    last_d = gnt_vld ? gnt_id : last_q;

    s_req = '0;
    if (gnt_vld) s_req = (gnt_id == MID_AUX) ? m1_req : m0_req;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= MID_AUX;
    else       last_q <= last_d;
  end

  assign m0_busy_o = m0_vld & ~(gnt_vld & (gnt_id == MID_CPU));
  assign m1_busy_o = m1_vld & ~(gnt_vld & (gnt_id == MID_AUX));

  assign s_addr_o  = s_req.addr;
  assign s_rstrb_o = s_req.rstrb;
  assign s_wmask_o = s_req.wmask;
  assign s_wdata_o = s_req.wdata;

  mem_rd_tag_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_tag_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_vld_i (s_req.rstrb),
    .in_id_i  (gnt_id),
    .out_vld_o(tag_vld),
    .out_id_o (tag_id)
  );

  // Read data is broadcast; only the tagged master's rvalid qualifies it.
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign m0_rvalid_o = tag_vld & (tag_id == MID_CPU);
  assign m1_rvalid_o = tag_vld & (tag_id == MID_AUX);

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] m0_grants_q, m0_grants_d;
  logic [31:0] m1_grants_q, m1_grants_d;
  logic [31:0] conflicts_q, conflicts_d;

  always_comb begin
    m0_grants_d = m0_grants_q;
    m1_grants_d = m1_grants_q;
    conflicts_d = conflicts_q;
    if (m0_vld && !m0_busy_o) m0_grants_d = sat_inc(m0_grants_q);
    if (m1_vld && !m1_busy_o) m1_grants_d = sat_inc(m1_grants_q);
    if (m0_vld && m1_vld)     conflicts_d = sat_inc(conflicts_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m0_grants_q <= '0;
      m1_grants_q <= '0;
      conflicts_q <= '0;
    end else begin
      m0_grants_q <= m0_grants_d;
      m1_grants_q <= m1_grants_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign m0_grants_o = m0_grants_q;
  assign m1_grants_o = m1_grants_q;
  assign conflicts_o = conflicts_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Three arbiters (RD_LATENCY 1..3) driven by the same masters, each with its own slave RAM
// model, checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        rstrb;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mreq_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] m_addr  [2];
  logic        m_rstrb [2];
  logic [3:0]  m_wmask [2];
  logic [31:0] m_wdata [2];

  wire [31:0] m0_rdata [1:3];
  wire [31:0] m1_rdata [1:3];
  wire        m0_rvalid[1:3];
  wire        m1_rvalid[1:3];
  wire        m0_busy  [1:3];
  wire        m1_busy  [1:3];
  wire [31:0] s_addr   [1:3];
  wire        s_rstrb  [1:3];
  wire [3:0]  s_wmask  [1:3];
  wire [31:0] s_wdata  [1:3];
  wire [31:0] s_rdata  [1:3];
`ifdef MEM_ARBITER_STATS_EN
  wire [31:0] m0_grants[1:3];
  wire [31:0] m1_grants[1:3];
  wire [31:0] conflicts[1:3];
`endif

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    logic [31:0] rline [0:3];
    always @(posedge clk) begin
      rline[0] <= s_rstrb[g] ? rom(s_addr[g]) : 32'h0;
      for (int i = 1; i < 4; i++) rline[i] <= rline[i-1];
    end
    assign s_rdata[g] = rline[g-1];

    mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .RD_LATENCY(g)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .m0_addr_i(m_addr[0]), .m0_rstrb_i(m_rstrb[0]), .m0_wmask_i(m_wmask[0]), .m0_wdata_i(m_wdata[0]),
      .m0_rdata_o(m0_rdata[g]), .m0_rvalid_o(m0_rvalid[g]), .m0_busy_o(m0_busy[g]),
      .m1_addr_i(m_addr[1]), .m1_rstrb_i(m_rstrb[1]), .m1_wmask_i(m_wmask[1]), .m1_wdata_i(m_wdata[1]),
      .m1_rdata_o(m1_rdata[g]), .m1_rvalid_o(m1_rvalid[g]), .m1_busy_o(m1_busy[g]),
`ifdef MEM_ARBITER_STATS_EN
      .m0_grants_o(m0_grants[g]), .m1_grants_o(m1_grants[g]), .conflicts_o(conflicts[g]),
`endif
      .s_addr_o(s_addr[g]), .s_rstrb_o(s_rstrb[g]), .s_wmask_o(s_wmask[g]), .s_wdata_o(s_wdata[g]),
      .s_rdata_i(s_rdata[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp_v, $time);
    end
  endtask

  // Reference model state: held requests, tie-break memory, issued reads in order.
  mreq_t       pend [2];
  mreq_t       scr0 [$];
  mreq_t       scr1 [$];
  bit          rand_mode = 0;
  int          cyc = 0;
  int          last_w = 1;
  int          stall [2];
  int          n_gnt [2];
  int          n_conf = 0;
  int          iss_cyc [$];
  int          iss_mid [$];
  logic [31:0] iss_addr [$];
  int          head [1:3];
  int          obs_log [$];

  function automatic mreq_t mk(input logic [31:0] a, input logic r, input logic [3:0] m,
                               input logic [31:0] d);
    mreq_t q;
    q.addr = a; q.rstrb = r; q.wmask = m; q.wdata = d;
    return q;
  endfunction

  function automatic mreq_t rand_req();
    int    k;
    mreq_t q;
    k = $urandom_range(0, 9);
    q = mk(32'($urandom_range(0, 255)) << 2, 1'b0, 4'h0, $urandom());
    if (k >= 3 && k <= 6) q.rstrb = 1'b1;
    else if (k >= 7 && k <= 8) q.wmask = 4'($urandom_range(1, 15));
    else if (k == 9) begin
      q.rstrb = 1'b1;
      q.wmask = 4'($urandom_range(1, 15));
    end
    if (k < 3) q = '0;
    return q;
  endfunction

  function automatic mreq_t next_req(input int i);
    if (i == 0 && scr0.size() > 0) return scr0.pop_front();
    if (i == 1 && scr1.size() > 0) return scr1.pop_front();
    if (rand_mode) return rand_req();
    return '0;
  endfunction

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      m_addr[i]  = pend[i].addr;
      m_rstrb[i] = pend[i].rstrb;
      m_wmask[i] = pend[i].wmask;
      m_wdata[i] = pend[i].wdata;
    end
  endtask

  task automatic step();
    bit    rq [2];
    int    win;
    int    exp_m;
    bit    exp_v;
    mreq_t e;
    @(negedge clk);
    for (int i = 0; i < 2; i++) rq[i] = pend[i].rstrb || (pend[i].wmask != 4'h0);
    if (rq[0] && rq[1]) win = (last_w == 0) ? 1 : 0;
    else if (rq[0])     win = 0;
    else if (rq[1])     win = 1;
    else                win = -1;
    e = '0;
    if (win >= 0) e = pend[win];

    for (int g = 1; g <= 3; g++) begin
      chk($sformatf("L%0d_m0_busy", g), m0_busy[g], rq[0] && win != 0);
      chk($sformatf("L%0d_m1_busy", g), m1_busy[g], rq[1] && win != 1);
      chk($sformatf("L%0d_s_addr", g), s_addr[g], e.addr);
      chk($sformatf("L%0d_s_rstrb", g), s_rstrb[g], e.rstrb);
      chk($sformatf("L%0d_s_wmask", g), s_wmask[g], e.wmask);
      chk($sformatf("L%0d_s_wdata", g), s_wdata[g], e.wdata);
      exp_v = head[g] < iss_cyc.size() && iss_cyc[head[g]] + g == cyc;
      exp_m = exp_v ? iss_mid[head[g]] : -1;
      chk($sformatf("L%0d_m0_rvalid", g), m0_rvalid[g], exp_m == 0);
      chk($sformatf("L%0d_m1_rvalid", g), m1_rvalid[g], exp_m == 1);
      if (exp_v) begin
        chk($sformatf("L%0d_m0_rdata", g), m0_rdata[g], rom(iss_addr[head[g]]));
        chk($sformatf("L%0d_m1_rdata", g), m1_rdata[g], rom(iss_addr[head[g]]));
        head[g]++;
      end
`ifdef MEM_ARBITER_STATS_EN
      chk($sformatf("L%0d_m0_grants", g), m0_grants[g], n_gnt[0]);
      chk($sformatf("L%0d_m1_grants", g), m1_grants[g], n_gnt[1]);
      chk($sformatf("L%0d_conflicts", g), conflicts[g], n_conf);
`endif
    end

    stall[0] = m0_busy[1] ? stall[0] + 1 : 0;
    stall[1] = m1_busy[1] ? stall[1] + 1 : 0;
    chk("m0_stall_run_le1", stall[0] <= 1, 1'b1);
    chk("m1_stall_run_le1", stall[1] <= 1, 1'b1);

    if (!rst) begin
      if (rq[0] && !m0_busy[1])      obs_log.push_back(0);
      else if (rq[1] && !m1_busy[1]) obs_log.push_back(1);
      else                           obs_log.push_back(-1);
      if (rq[0] && rq[1]) n_conf++;
      if (win >= 0) begin
        last_w = win;
        n_gnt[win]++;
        if (pend[win].rstrb) begin
          iss_cyc.push_back(cyc);
          iss_mid.push_back(win);
          iss_addr.push_back(pend[win].addr);
        end
        pend[win] = next_req(win);
      end
      for (int i = 0; i < 2; i++) if (!rq[i]) pend[i] = next_req(i);
    end

    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend[0] = '0;
    pend[1] = '0;
    drive();
    iss_cyc.delete();
    iss_mid.delete();
    iss_addr.delete();
    obs_log.delete();
    for (int g = 1; g <= 3; g++) head[g] = 0;
    last_w = 1;
    n_gnt[0] = 0; n_gnt[1] = 0; n_conf = 0;
    stall[0] = 0; stall[1] = 0;
    step();
    step();
    rst = 1'b0;
    pend[0] = next_req(0);
    pend[1] = next_req(1);
    drive();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Tie on the first cycle after reset: m0 read first, then m1's write.
    scr0.push_back(mk(32'h10, 1'b1, 4'h0, 32'h0));
    scr1.push_back(mk(32'h20, 1'b0, 4'hF, 32'hDEADBEEF));
    do_reset();
    step();
    step();
    chk("tie_first_winner", obs_log[0], 0);
    chk("tie_second_winner", obs_log[1], 1);
    idle(4);

    // m0 alone reads 0x100.
    scr0.push_back(mk(32'h100, 1'b1, 4'h0, 32'h0));
    idle(5);

    // Six cycles of sustained conflict from reset.
    for (int i = 0; i < 4; i++) scr0.push_back(mk(32'h40 + 32'(i * 4), 1'b1, 4'h0, 32'h0));
    scr1.push_back(mk(32'h80, 1'b0, 4'h3, 32'h11112222));
    scr1.push_back(mk(32'h84, 1'b1, 4'h0, 32'h0));
    scr1.push_back(mk(32'h88, 1'b1, 4'hC, 32'h33334444));
    do_reset();
    idle(6);
    for (int i = 0; i < 6; i++) chk($sformatf("alt_grant_%0d", i), obs_log[i], i % 2);
`ifdef MEM_ARBITER_STATS_EN
    chk("stats_m0_grants", m0_grants[1], 3);
    chk("stats_m1_grants", m1_grants[1], 3);
    chk("stats_conflicts", conflicts[1], 6);
`endif
    idle(6);

    // Reads accepted m0, m1, m0 back to back.
    scr0.push_back(mk(32'h300, 1'b1, 4'h0, 32'h0));
    scr0.push_back(mk(32'h308, 1'b1, 4'h0, 32'h0));
    scr1.push_back(mk(32'h304, 1'b1, 4'h0, 32'h0));
    do_reset();
    idle(8);
    chk("b2b_order_0", obs_log[0], 0);
    chk("b2b_order_1", obs_log[1], 1);
    chk("b2b_order_2", obs_log[2], 0);

    // Reset one cycle after a read issues; the next tie must go to m0.
    do_reset();
    scr0.push_back(mk(32'h500, 1'b1, 4'h0, 32'h0));
    step();
    step();
    scr0.push_back(mk(32'h600, 1'b1, 4'h0, 32'h0));
    scr1.push_back(mk(32'h604, 1'b1, 4'h0, 32'h0));
    do_reset();
    idle(6);
    chk("post_reset_tie", obs_log[0], 0);

    // Random traffic with occasional resets.
    rand_mode = 1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step();
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    rand_mode = 0;
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
